// File: rtl/seg_display_scan_n.sv
// seg_display_scan_n: multiplexed seven-segment driver with a
// sequential double-dabble converter and internal refresh scan.
module seg_display_scan_n #(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGITS      = 8,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  signed_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [DIGITS-1:0]     AN,
  output logic [6:0]            SEG
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [6:0] G_DASH  = 7'b0111111;
  localparam logic [6:0] G_BLANK = 7'b1111111;

  // The capture happens on the load edge itself, so IDLE doubles as CAPTURE.
  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mag;
  logic [BW-1:0]         bcd;
  logic [BW-1:0]         bcd_adj;
  logic [BW-1:0]         disp_bcd;
  logic [CW-1:0]         cnt;
  logic                  neg;
  logic                  ovf_w;
  logic                  disp_neg;
  logic [PW-1:0]         pre;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         msd;
  logic [3:0]            digit;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = G_BLANK;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (load) state_nx = CONVERT;
      CONVERT: if (cnt == CW'(DATA_WIDTH - 1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int j = 0; j < DIGITS; j++) begin
      if (bcd[4*j +: 4] >= 4'd5) bcd_adj[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      mag      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      neg      <= 1'b0;
      ovf_w    <= 1'b0;
      disp_bcd <= '0;
      disp_neg <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            mag   <= (signed_mode && data[DATA_WIDTH-1]) ?
                     (~data + DATA_WIDTH'(1)) : data;
            neg   <= signed_mode & data[DATA_WIDTH-1];
            bcd   <= '0;
            cnt   <= '0;
            ovf_w <= 1'b0;
          end
        end
        CONVERT: begin
          bcd   <= {bcd_adj[BW-2:0], mag[DATA_WIDTH-1]};
          mag   <= {mag[DATA_WIDTH-2:0], 1'b0};
          cnt   <= cnt + CW'(1);
          ovf_w <= ovf_w | bcd_adj[BW-1];
        end
        COMMIT: begin
          disp_bcd <= bcd;
          disp_neg <= neg;
          // a negative value needs the top digit free for its sign
          overflow <= ovf_w | (neg & (|bcd[BW-1 -: 4]));
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PW'(REFRESH_DIV - 1)) begin
      pre <= '0;
      idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      pre <= pre + PW'(1);
    end
  end

  always_comb begin
    msd = '0;
    for (int j = 1; j < DIGITS; j++) begin
      if (disp_bcd[4*j +: 4] != 4'd0) msd = IW'(j);
    end
  end

  assign digit = disp_bcd[{idx, 2'b00} +: 4];

  always_comb begin
    SEG = G_BLANK;
    if (overflow)
      SEG = G_DASH;
    else if (idx <= msd)
      SEG = glyph(digit);
    else if (disp_neg && (int'(idx) == int'(msd) + 1))
      SEG = G_DASH;
    else if (!blank_lz)
      SEG = glyph(4'd0);
  end

  assign AN   = ~(DIGITS'(1) << idx);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_seg_display_scan_n.sv
// tb_seg_display_scan_n: directed checks of conversion, rendering,
// overflow, load rejection and anode scanning.
module tb_seg_display_scan_n;
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] DA = 7'b0111111;
  localparam logic [6:0] BL = 7'b1111111;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        blank_lz = 1'b1;

  logic        load_a = 1'b0;
  logic        sm_a = 1'b0;
  logic [31:0] data_a = '0;
  logic        busy_a, done_a, ovf_a;
  logic [7:0]  an_a;
  logic [6:0]  seg_a;

  logic        load_b = 1'b0;
  logic        sm_b = 1'b0;
  logic [15:0] data_b = '0;
  logic        busy_b, done_b, ovf_b;
  logic [3:0]  an_b;
  logic [6:0]  seg_b;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  seg_display_scan_n #(
    .DATA_WIDTH(32), .DIGITS(8), .REFRESH_DIV(2)
  ) dut_a (
    .clock(clock), .reset(reset), .load(load_a), .data(data_a),
    .signed_mode(sm_a), .blank_lz(blank_lz), .busy(busy_a),
    .done(done_a), .overflow(ovf_a), .AN(an_a), .SEG(seg_a)
  );

  seg_display_scan_n #(
    .DATA_WIDTH(16), .DIGITS(4), .REFRESH_DIV(3)
  ) dut_b (
    .clock(clock), .reset(reset), .load(load_b), .data(data_b),
    .signed_mode(sm_b), .blank_lz(blank_lz), .busy(busy_b),
    .done(done_b), .overflow(ovf_b), .AN(an_b), .SEG(seg_b)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic seg_of_a(input int i, output logic [6:0] s);
    int t = 0;
    logic [7:0] want;
    want = ~(8'd1 << i);
    while (an_a !== want && t < 40) begin
      @(negedge clock);
      t++;
    end
    check($sformatf("scan_a_found%0d", i), 32'(t < 40), 32'd1);
    s = seg_a;
  endtask

  task automatic seg_of_b(input int i, output logic [6:0] s);
    int t = 0;
    logic [3:0] want;
    want = ~(4'd1 << i);
    while (an_b !== want && t < 40) begin
      @(negedge clock);
      t++;
    end
    check($sformatf("scan_b_found%0d", i), 32'(t < 40), 32'd1);
    s = seg_b;
  endtask

  task automatic digits_a(input string tag, input logic [55:0] exp);
    logic [6:0] s;
    for (int i = 0; i < 8; i++) begin
      seg_of_a(i, s);
      check($sformatf("%s_d%0d", tag, i), 32'(s), 32'(exp[7*i +: 7]));
    end
  endtask

  task automatic digits_b(input string tag, input logic [27:0] exp);
    logic [6:0] s;
    for (int i = 0; i < 4; i++) begin
      seg_of_b(i, s);
      check($sformatf("%s_d%0d", tag, i), 32'(s), 32'(exp[7*i +: 7]));
    end
  endtask

  task automatic load_a_t(input logic [31:0] d, input logic sm);
    data_a = d;
    sm_a   = sm;
    load_a = 1'b1;
    @(negedge clock);
    load_a = 1'b0;
  endtask

  task automatic load_b_t(input logic [15:0] d, input logic sm);
    data_b = d;
    sm_b   = sm;
    load_b = 1'b1;
    @(negedge clock);
    load_b = 1'b0;
  endtask

  task automatic wait_done_a();
    int t = 0;
    while (!done_a && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("done_a_seen", 32'(t < 100), 32'd1);
  endtask

  task automatic wait_done_b();
    int t = 0;
    while (!done_b && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("done_b_seen", 32'(t < 100), 32'd1);
  endtask

  initial begin
    int cnt;
    int nd;
    logic [3:0] e;

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // anode scan on the 4-digit instance, straight out of reset
    for (int n = 0; n < 13; n++) begin
      e = ~(4'd1 << ((n / 3) % 4));
      check($sformatf("scan_b_n%0d", n), 32'(an_b), 32'(e));
      @(negedge clock);
    end

    // reset in the middle of a conversion
    load_a_t(32'd1234, 1'b0);
    repeat (3) @(negedge clock);
    check("busy_mid", 32'(busy_a), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_an", 32'(an_a), 32'hFE);
    check("rst_seg", 32'(seg_a), 32'(G0));
    reset = 1'b1;

    // 1234 unsigned, latency and leading-zero control
    load_a_t(32'd1234, 1'b0);
    cnt = 0;
    while (busy_a && cnt < 100) begin
      cnt++;
      @(negedge clock);
    end
    check("busy_len", 32'(cnt), 32'd33);
    check("done_pulse", 32'(done_a), 32'd1);
    @(negedge clock);
    check("done_clear", 32'(done_a), 32'd0);
    check("t2_ovf", 32'(ovf_a), 32'd0);
    digits_a("t2_blank", {BL, BL, BL, BL, G1, G2, G3, G4});
    blank_lz = 1'b0;
    digits_a("t2_zero", {G0, G0, G0, G0, G1, G2, G3, G4});
    blank_lz = 1'b1;

    // -42 signed, then the same bits unsigned overflow
    load_a_t(32'hFFFFFFD6, 1'b1);
    wait_done_a();
    check("t3_neg_ovf", 32'(ovf_a), 32'd0);
    digits_a("t3_neg", {BL, BL, BL, BL, BL, DA, G4, G2});
    load_a_t(32'hFFFFFFD6, 1'b0);
    wait_done_a();
    check("t3_uns_ovf", 32'(ovf_a), 32'd1);
    digits_a("t3_uns", {DA, DA, DA, DA, DA, DA, DA, DA});

    // second load while busy is dropped
    load_a_t(32'd777, 1'b0);
    @(negedge clock);
    check("t4_busy", 32'(busy_a), 32'd1);
    load_a_t(32'd5, 1'b0);
    nd = 0;
    repeat (60) begin
      @(negedge clock);
      if (done_a) nd++;
    end
    check("t4_done_cnt", 32'(nd), 32'd1);
    check("t4_ovf", 32'(ovf_a), 32'd0);
    digits_a("t4", {BL, BL, BL, BL, BL, G7, G7, G7});

    // 4-digit signed limits
    load_b_t(16'hFC19, 1'b1);
    wait_done_b();
    check("t6_m999_ovf", 32'(ovf_b), 32'd0);
    digits_b("t6_m999", {DA, G9, G9, G9});
    load_b_t(16'hFC18, 1'b1);
    wait_done_b();
    check("t6_m1000_ovf", 32'(ovf_b), 32'd1);
    digits_b("t6_m1000", {DA, DA, DA, DA});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
